// File: rtl/fetch_aligner_pkg.sv
// Shared types and constants for the instruction fetch aligner.
// Covers the FSM state encoding, halfword geometry and buffer depth.
package fetch_aligner_pkg;

  typedef enum logic [1:0] {
    ST_FETCH     = 2'd0,
    ST_WAIT      = 2'd1,
    ST_WAIT_DROP = 2'd2
  } fetch_state_t;

  localparam logic [1:0] QUAD_UNCOMP = 2'b11;
  localparam int         HW_BITS     = 16;
  localparam int         BUF_DEPTH   = 4;
  localparam int         CNT_BITS    = 3;

  // A halfword starts a 16-bit instruction unless its quadrant bits are 11.
  function automatic logic is_compressed(input logic [HW_BITS-1:0] hw);
    return hw[1:0] != QUAD_UNCOMP;
  endfunction

endpackage

// File: rtl/fetch_halfword_buffer.sv
// Four-entry halfword shift buffer: pop 0/1/2 from the head and push 0/1/2 at the tail in one cycle.
// Registered state only; the caller guarantees pops never exceed count and pushes never overflow.
module fetch_halfword_buffer
  import fetch_aligner_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [1:0]          pop_cnt,
  input  logic [1:0]          push_cnt,
  input  logic [HW_BITS-1:0]  push_hw0,
  input  logic [HW_BITS-1:0]  push_hw1,
  output logic [HW_BITS-1:0]  head_hw0,
  output logic [HW_BITS-1:0]  head_hw1,
  output logic [CNT_BITS-1:0] count
);

  logic [BUF_DEPTH-1:0][HW_BITS-1:0] entries_q, entries_d, shifted;
  logic [CNT_BITS-1:0]               count_q, count_d, remain;

  // Entries at or above count are kept zero, so the shift can fill from the top freely.
  always_comb begin
    shifted   = entries_q >> (HW_BITS * pop_cnt);
    remain    = count_q - CNT_BITS'(pop_cnt);
    entries_d = shifted;
    for (int j = 0; j < BUF_DEPTH; j++) begin
      if (push_cnt != 2'd0 && CNT_BITS'(j) == remain) entries_d[j] = push_hw0;
      if (push_cnt == 2'd2 && CNT_BITS'(j) == remain + CNT_BITS'(1)) entries_d[j] = push_hw1;
    end
    count_d = remain + CNT_BITS'(push_cnt);
    if (clear) begin
      entries_d = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
    end
  end

  assign head_hw0 = entries_q[0];
  assign head_hw1 = entries_q[1];
  assign count    = count_q;

endmodule

// File: rtl/fetch_aligner.sv
// Word fetcher plus halfword aligner emitting 16/32-bit instructions; one fetch outstanding at a time.
// Instruction outputs come from registered state only and hold while instr_ready is low.
module fetch_aligner
  import fetch_aligner_pkg::*;
#(
  parameter int                 RegBits = 32,
  parameter logic [RegBits-1:0] ResetPc = RegBits'(32'h0000_0000)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_req,
  output logic [RegBits-1:0] mem_addr,
  input  logic               mem_valid,
  input  logic [RegBits-1:0] mem_rdata,
  input  logic               redirect,
  input  logic [RegBits-1:0] redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [RegBits-1:0] instr,
  output logic [RegBits-1:0] instr_pc,
  output logic               instr_compressed
);

  fetch_state_t        state_q, state_d;
  logic [RegBits-1:0]  fetch_pc_q, head_pc_q;
  logic                skip_half_q;

  logic [HW_BITS-1:0]  head_hw0, head_hw1;
  logic [CNT_BITS-1:0] count;
  logic                head_comp, fire, accept, has_room;
  logic [1:0]          pop_cnt, push_cnt;
  logic [HW_BITS-1:0]  push_hw0, push_hw1;

  assign head_comp   = is_compressed(head_hw0);
  assign instr_valid = (count != '0 && head_comp) || count >= CNT_BITS'(2);
  assign has_room    = count <= CNT_BITS'(2);

  assign instr_compressed = instr_valid && head_comp;
  assign instr    = !instr_valid ? '0 :
                    head_comp    ? RegBits'(head_hw0) : RegBits'({head_hw1, head_hw0});
  assign instr_pc = head_pc_q;
  assign mem_addr = fetch_pc_q;

  // Redirect wins over everything: it blocks consume, append and issue this cycle.
  assign fire     = instr_valid && instr_ready && !redirect;
  assign accept   = state_q == ST_WAIT && mem_valid && !redirect;
  assign pop_cnt  = fire ? (head_comp ? 2'd1 : 2'd2) : 2'd0;
  assign push_cnt = accept ? (skip_half_q ? 2'd1 : 2'd2) : 2'd0;
  assign push_hw0 = skip_half_q ? mem_rdata[2*HW_BITS-1:HW_BITS] : mem_rdata[HW_BITS-1:0];
  assign push_hw1 = mem_rdata[2*HW_BITS-1:HW_BITS];

  fetch_halfword_buffer u_buf (
    .clk      (clk),
    .rst      (rst),
    .clear    (redirect),
    .pop_cnt  (pop_cnt),
    .push_cnt (push_cnt),
    .push_hw0 (push_hw0),
    .push_hw1 (push_hw1),
    .head_hw0 (head_hw0),
    .head_hw1 (head_hw1),
    .count    (count)
  );

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (!redirect && has_room) begin
          mem_req = !rst;
          state_d = ST_WAIT;
        end
      end
      // A response always retires the outstanding fetch, even when it is being dropped.
      ST_WAIT, ST_WAIT_DROP: begin
        if (mem_valid)     state_d = ST_FETCH;
        else if (redirect) state_d = ST_WAIT_DROP;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      fetch_pc_q  <= {ResetPc[RegBits-1:2], 2'b00};
      head_pc_q   <= ResetPc;
      skip_half_q <= ResetPc[1];
    end else begin
      state_q <= state_d;
      if (redirect) begin
        fetch_pc_q  <= redirect_pc & ~RegBits'(3);
        head_pc_q   <= redirect_pc & ~RegBits'(1);
        skip_half_q <= redirect_pc[1];
      end else begin
        if (accept) begin
          fetch_pc_q  <= fetch_pc_q + RegBits'(4);
          skip_half_q <= 1'b0;
        end
        if (fire) head_pc_q <= head_pc_q + (head_comp ? RegBits'(2) : RegBits'(4));
      end
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Bench for fetch_aligner: a memory image drives fetch responses and an instruction-stream model
// walks the image by PC to predict every transferred instruction.
module tb_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_valid, redirect, instr_valid, instr_ready, instr_compressed;
  logic [31:0] mem_addr, mem_rdata, redirect_pc, instr, instr_pc;

  fetch_aligner dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_compressed(instr_compressed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] image [256];
  bit          outstanding, drop, after_redirect, prev_hold, stale_pending, force_redir, prev_comp;
  int          lat_cnt, lat_min, lat_max, ready_pct, redir_pct, n_req, n_resp;
  logic [31:0] req_addr, exp_pc, exp_fetch, prev_instr, prev_pc, force_pc;
  logic [31:0] got_instr[$], got_pc[$], req_log[$];
  bit          got_comp[$];
  int          got_resp[$];

  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    logic [31:0] w;
    w = image[pc[9:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] pick_pc();
    logic [31:0] p;
    p = $urandom;
    if ($urandom_range(3) == 0) p = 32'hFFFF_FFF0 | (p & 32'hF);
    return p;
  endfunction

  task automatic fill_image(input logic [31:0] w);
    for (int i = 0; i < 256; i++) image[i] = w;
  endtask

  task automatic model_reset();
    outstanding = 0; drop = 0; after_redirect = 0; prev_hold = 0; force_redir = 0;
    exp_pc = 32'h0; exp_fetch = 32'h0; n_req = 0; n_resp = 0;
    got_instr.delete(); got_pc.delete(); got_comp.delete(); got_resp.delete(); req_log.delete();
  endtask

  // Leaves the bench on a falling edge with rst released, ready for step().
  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; mem_valid = 1'b0; instr_ready = 1'b0;
    mem_rdata = 32'h0; redirect_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs at the falling edge, check 1 time unit later, advance the model.
  task automatic step();
    logic [15:0] hw;
    logic [31:0] exp_i;
    bit          full, resp;
    redirect = 1'b0;
    if (force_redir) begin
      redirect = 1'b1; redirect_pc = force_pc; force_redir = 0;
    end else if (redir_pct > 0 && $urandom_range(99) < redir_pct) begin
      redirect = 1'b1; redirect_pc = pick_pc();
    end
    resp      = outstanding && lat_cnt == 0;
    mem_valid = 1'b0;
    mem_rdata = $urandom;
    if (resp) begin
      mem_valid = 1'b1; mem_rdata = image[req_addr[9:2]];
    end else if (stale_pending) begin
      mem_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    end
    stale_pending = 0;
    instr_ready = ($urandom_range(99) < ready_pct);
    #1;
    if (after_redirect) begin
      n_checks++;
      if (instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL valid_after_redirect: got %b want 0", instr_valid);
      end
    end
    if (prev_hold) begin
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== prev_instr || instr_pc !== prev_pc ||
          instr_compressed !== prev_comp) begin
        n_fail++;
        $display("FAIL hold_stable: got v=%b %h @%h c=%b want v=1 %h @%h c=%b",
                 instr_valid, instr, instr_pc, instr_compressed, prev_instr, prev_pc, prev_comp);
      end
    end
    if (redirect) begin
      n_checks++;
      if (mem_req !== 1'b0) begin
        n_fail++; $display("FAIL req_during_redirect: got %b want 0", mem_req);
      end
    end else if (mem_req === 1'b1) begin
      n_checks++;
      if (outstanding || mem_addr !== exp_fetch) begin
        n_fail++;
        $display("FAIL mem_req: got addr %h outstanding=%0d want addr %h outstanding=0",
                 mem_addr, outstanding, exp_fetch);
      end
    end
    if (!redirect && instr_valid === 1'b1 && instr_ready) begin
      hw    = hw_at(exp_pc);
      full  = hw[1:0] == 2'b11;
      exp_i = full ? {hw_at(exp_pc + 32'd2), hw} : {16'h0, hw};
      n_checks++;
      if (instr !== exp_i || instr_pc !== exp_pc || instr_compressed !== !full) begin
        n_fail++;
        $display("FAIL transfer: got %h @%h c=%b want %h @%h c=%b",
                 instr, instr_pc, instr_compressed, exp_i, exp_pc, !full);
      end
      got_instr.push_back(instr); got_pc.push_back(instr_pc);
      got_comp.push_back(instr_compressed); got_resp.push_back(n_resp);
      exp_pc = exp_pc + (full ? 32'd4 : 32'd2);
    end
    if (resp) begin
      outstanding = 0;
      if (!drop && !redirect) begin
        exp_fetch = exp_fetch + 32'd4; n_resp++;
      end
      drop = 0;
    end else if (outstanding) begin
      lat_cnt--;
    end
    if (mem_req === 1'b1 && !redirect) begin
      outstanding = 1; drop = 0; req_addr = mem_addr; n_req++;
      lat_cnt = $urandom_range(lat_max, lat_min);
      req_log.push_back(mem_addr);
    end
    if (redirect) begin
      if (outstanding) drop = 1;
      exp_pc    = redirect_pc & ~32'h1;
      exp_fetch = redirect_pc & ~32'h3;
    end
    after_redirect = redirect;
    prev_hold  = instr_valid === 1'b1 && !instr_ready && !redirect;
    prev_instr = instr; prev_pc = instr_pc; prev_comp = instr_compressed;
    @(negedge clk);
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int c = 0;
    while (got_instr.size() < n && c < budget) begin
      step();
      c++;
    end
    n_checks++;
    if (got_instr.size() < n) begin
      n_fail++; $display("FAIL xfer_timeout: got %0d transfers want %0d", got_instr.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; mem_valid = 1'b0; instr_ready = 1'b1;
    mem_rdata = 32'h0; redirect_pc = 32'h0;
    @(negedge clk);
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_mem: got req=%b addr=%h want 0 0", mem_req, mem_addr);
    end
    n_checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_compressed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_instr: got v=%b %h c=%b want 0 0 0", instr_valid, instr, instr_compressed);
    end
    n_checks++;
    if (instr_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc: got %h want 0", instr_pc);
    end
  endtask

  task automatic test_full_word();
    fill_image(32'h0001_0001);
    image[0] = 32'h0041_0513;
    lat_min = 0; lat_max = 0; ready_pct = 100; redir_pct = 0;
    do_reset();
    wait_xfers(1, 20);
    n_checks++;
    if (got_instr.size() < 1 || got_instr[0] !== 32'h0041_0513 || got_pc[0] !== 32'h0 ||
        got_comp[0] !== 1'b0) begin
      n_fail++; $display("FAIL full_word: first instr %h @%h want 00410513 @0 c=0",
                         got_instr.size() > 0 ? got_instr[0] : 32'hx, got_pc.size() > 0 ? got_pc[0] : 32'hx);
    end
  endtask

  task automatic test_compressed_pair();
    fill_image(32'h0001_0001);
    image[0] = 32'h4505_4501;
    lat_min = 0; lat_max = 2; ready_pct = 100; redir_pct = 0;
    do_reset();
    wait_xfers(2, 30);
    n_checks++;
    if (got_instr.size() < 2 || got_instr[0] !== 32'h4501 || got_pc[0] !== 32'h0 || !got_comp[0] ||
        got_instr[1] !== 32'h4505 || got_pc[1] !== 32'h2 || !got_comp[1]) begin
      n_fail++; $display("FAIL compressed_pair: got %0d transfers, want 4501@0 4505@2 compressed",
                         got_instr.size());
    end
  endtask

  task automatic test_spanning();
    fill_image(32'h0001_0001);
    image[0] = 32'h0513_4501;
    image[1] = 32'hABCD_0041;
    lat_min = 0; lat_max = 4; ready_pct = 100; redir_pct = 0;
    do_reset();
    wait_xfers(2, 40);
    n_checks++;
    if (got_instr.size() < 2 || got_instr[0] !== 32'h4501 || got_pc[0] !== 32'h0 ||
        got_instr[1] !== 32'h0041_0513 || got_pc[1] !== 32'h2 || got_comp[1] !== 1'b0) begin
      n_fail++; $display("FAIL spanning: got %0d transfers, want 4501@0 then 00410513@2",
                         got_instr.size());
    end
    n_checks++;
    if (got_resp.size() < 2 || got_resp[1] < 2) begin
      n_fail++; $display("FAIL span_early: spanning instr emitted after %0d words, want >=2",
                         got_resp.size() > 1 ? got_resp[1] : -1);
    end
  endtask

  task automatic test_redirect_in_wait();
    int c = 0;
    fill_image(32'h0001_0001);
    image[0]    = 32'h4501_4501;
    image[8'h40] = 32'h4509_1111;
    lat_min = 3; lat_max = 3; ready_pct = 100; redir_pct = 0;
    do_reset();
    while (!outstanding && c < 5) begin
      step();
      c++;
    end
    n_checks++;
    if (!outstanding) begin
      n_fail++; $display("FAIL redirect_setup: got no fetch in flight want one");
    end
    req_log.delete();
    force_redir = 1; force_pc = 32'h0000_0102;
    wait_xfers(1, 40);
    n_checks++;
    if (req_log.size() < 1 || req_log[0] !== 32'h100) begin
      n_fail++; $display("FAIL redirect_addr: got %h want 00000100",
                         req_log.size() > 0 ? req_log[0] : 32'hx);
    end
    n_checks++;
    if (got_instr.size() < 1 || got_pc[0] !== 32'h102 || got_instr[0] !== 32'h4509) begin
      n_fail++; $display("FAIL redirect_first: got %h @%h want 4509 @102",
                         got_instr.size() > 0 ? got_instr[0] : 32'hx, got_pc.size() > 0 ? got_pc[0] : 32'hx);
    end
  endtask

  task automatic test_backpressure();
    fill_image(32'h4505_4501);
    lat_min = 0; lat_max = 0; ready_pct = 0; redir_pct = 0;
    do_reset();
    for (int i = 0; i < 20; i++) step();
    n_checks++;
    if (n_req != 2) begin
      n_fail++; $display("FAIL full_no_req: got %0d fetches want 2", n_req);
    end
    #1;
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h0000_4501 || instr_pc !== 32'h0) begin
      n_fail++; $display("FAIL full_head: got v=%b %h @%h want 1 4501 @0", instr_valid, instr, instr_pc);
    end
    ready_pct = 100;
    wait_xfers(6, 40);
  endtask

  task automatic test_reset_mid_wait();
    int c = 0;
    fill_image(32'h0001_0001);
    image[0] = 32'h0041_0513;
    lat_min = 6; lat_max = 6; ready_pct = 100; redir_pct = 0;
    do_reset();
    while (!outstanding && c < 5) begin
      step();
      c++;
    end
    do_reset();
    stale_pending = 1;
    lat_min = 1; lat_max = 3;
    wait_xfers(1, 30);
    n_checks++;
    if (req_log.size() < 1 || req_log[0] !== 32'h0) begin
      n_fail++; $display("FAIL restart_addr: got %h want 0", req_log.size() > 0 ? req_log[0] : 32'hx);
    end
    n_checks++;
    if (got_instr.size() < 1 || got_instr[0] !== 32'h0041_0513 || got_pc[0] !== 32'h0) begin
      n_fail++; $display("FAIL stale_ignored: got %h @%h want 00410513 @0",
                         got_instr.size() > 0 ? got_instr[0] : 32'hx, got_pc.size() > 0 ? got_pc[0] : 32'hx);
    end
  endtask

  task automatic test_random();
    logic [15:0] h0, h1;
    for (int i = 0; i < 256; i++) begin
      h0 = 16'($urandom); h1 = 16'($urandom);
      h0[1:0] = $urandom_range(1) ? 2'b11 : 2'(($urandom_range(2)));
      h1[1:0] = $urandom_range(1) ? 2'b11 : 2'(($urandom_range(2)));
      image[i] = {h1, h0};
    end
    lat_min = 0; lat_max = 3; ready_pct = 70; redir_pct = 4;
    do_reset();
    for (int i = 0; i < 3000; i++) step();
    redir_pct = 0; ready_pct = 60;
    for (int i = 0; i < 500; i++) step();
    n_checks++;
    if (got_instr.size() < 200) begin
      n_fail++; $display("FAIL random_progress: got %0d transfers want >=200", got_instr.size());
    end
  endtask

  initial begin
    stale_pending = 0;
    model_reset();
    test_reset();
    test_full_word();
    test_compressed_pair();
    test_spanning();
    test_redirect_in_wait();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
